jt1942_dwnld_router: RTL

- Parametrised successor of the game ROM-download mapper.
- Sits between the ioctl download port and the SDRAM programming port (clk_rom domain).
- Classifies each downloaded byte into three regions: CPU/char, object (with byte-lane swap bit) or PROM.
- Drives SDRAM writes through a prog_we/prog_rdy handshake with a 2-entry skid buffer, pulses PROM write enables, and signals download completion after draining.

---
 rtl/jt1942_dwnld_router.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/jt1942_dwnld_router.sv
// ROM download router: classifies ioctl bytes into CPU/object/PROM regions,
// feeds SDRAM through a two-entry skid buffer and pulses PROM write enables.
module jt1942_dwnld_router #(
  parameter logic [21:0] OBJ_START = 22'h1A000,
  parameter logic [21:0] OBJ_LEN   = 22'h20000,
  parameter int unsigned SWAB_BIT  = 14,
  parameter int unsigned PROM_CNT  = 10,
  parameter int unsigned PROM_AW   = 8
) (
  input  logic                clk_rom,
  input  logic                rst_n,
  input  logic                downloading,
  input  logic                ioctl_wr,
  input  logic [21:0]         ioctl_addr,
  input  logic [7:0]          ioctl_data,
  output logic [21:0]         prog_addr,
  output logic [7:0]          prog_data,
  output logic [1:0]          prog_mask,
  output logic                prog_we,
  input  logic                prog_rdy,
  output logic [PROM_CNT-1:0] prom_we,
  output logic [PROM_AW-1:0]  prom_addr,
  output logic [7:0]          prom_data,
  output logic                dwnld_done,
  output logic                overflow
);

  localparam logic [21:0] OBJ_END  = OBJ_START + OBJ_LEN;
  localparam logic [21:0] LOW_MASK = (22'd1 << SWAB_BIT) - 22'd1;

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN} state_t;
  state_t state, state_nxt;

  logic [21:0]         obj_off, obj_full, prom_off, prom_idx;
  logic [21:0]         dec_addr;
  logic [1:0]          dec_mask;
  logic                is_sdram, is_prom;
  logic [PROM_CNT-1:0] prom_onehot;

  logic        head_v, skid_v;
  logic [21:0] head_addr, skid_addr;
  logic [7:0]  head_data, skid_data;
  logic [1:0]  head_mask, skid_mask;
  logic        accept, enter_load;

  // Region decode of the current ioctl byte
  always_comb begin
    obj_full    = ioctl_addr - OBJ_START;
    obj_off     = ((obj_full >> (SWAB_BIT + 1)) << SWAB_BIT) | (obj_full & LOW_MASK);
    prom_off    = ioctl_addr - OBJ_END;
    prom_idx    = prom_off >> PROM_AW;
    dec_addr    = {1'b0, ioctl_addr[21:1]};
    dec_mask    = {ioctl_addr[0], ~ioctl_addr[0]};
    is_sdram    = 1'b0;
    is_prom     = 1'b0;
    prom_onehot = '0;
    if (ioctl_addr < OBJ_START) begin
      is_sdram = ioctl_wr;
    end else if (ioctl_addr < OBJ_END) begin
      is_sdram = ioctl_wr;
      dec_addr = (OBJ_START >> 1) + obj_off;
      dec_mask = {obj_full[SWAB_BIT], ~obj_full[SWAB_BIT]};
    end else begin
      is_prom = ioctl_wr && (prom_idx < 22'(PROM_CNT));
      for (int unsigned i = 0; i < PROM_CNT; i++) begin
        prom_onehot[i] = (prom_idx == 22'(i));
      end
    end
  end

  assign accept     = head_v && prog_rdy;
  assign prog_we    = head_v;
  assign prog_addr  = head_addr;
  assign prog_data  = head_data;
  assign prog_mask  = head_v ? head_mask : 2'b00;
  assign enter_load = (state != LOAD) && (state_nxt == LOAD);

  // Skid buffer: head drives the SDRAM port, skid catches a byte during back-pressure
  always_ff @(posedge clk_rom or negedge rst_n) begin
    if (!rst_n) begin
      head_v    <= 1'b0;
      skid_v    <= 1'b0;
      head_addr <= '0;
      head_data <= '0;
      head_mask <= '0;
      skid_addr <= '0;
      skid_data <= '0;
      skid_mask <= '0;
      overflow  <= 1'b0;
    end else begin
      if (enter_load) overflow <= 1'b0;
      if (accept) begin
        if (skid_v) begin
          head_addr <= skid_addr;
          head_data <= skid_data;
          head_mask <= skid_mask;
          if (is_sdram) begin
            skid_addr <= dec_addr;
            skid_data <= ioctl_data;
            skid_mask <= dec_mask;
          end else begin
            skid_v <= 1'b0;
          end
        end else if (is_sdram) begin
          head_addr <= dec_addr;
          head_data <= ioctl_data;
          head_mask <= dec_mask;
        end else begin
          head_v <= 1'b0;
        end
      end else if (is_sdram) begin
        if (!head_v) begin
          head_v    <= 1'b1;
          head_addr <= dec_addr;
          head_data <= ioctl_data;
          head_mask <= dec_mask;
        end else if (!skid_v) begin
          skid_v    <= 1'b1;
          skid_addr <= dec_addr;
          skid_data <= ioctl_data;
          skid_mask <= dec_mask;
        end else begin
          overflow <= 1'b1;
        end
      end
    end
  end

  // PROM write pulse, one cycle after the strobe
  always_ff @(posedge clk_rom or negedge rst_n) begin
    if (!rst_n) begin
      prom_we   <= '0;
      prom_addr <= '0;
      prom_data <= '0;
    end else begin
      prom_we <= is_prom ? prom_onehot : '0;
      if (is_prom) begin
        prom_addr <= prom_off[PROM_AW-1:0];
        prom_data <= ioctl_data;
      end
    end
  end

  // Download FSM state register
  always_ff @(posedge clk_rom or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Download FSM next state and completion pulse
  always_comb begin
    state_nxt  = state;
    dwnld_done = 1'b0;
    case (state)
      IDLE:  if (downloading) state_nxt = LOAD;
      LOAD:  if (!downloading) state_nxt = DRAIN;
      DRAIN: begin
        if (downloading) begin
          state_nxt = LOAD;
        end else if (!head_v) begin
          state_nxt  = IDLE;
          dwnld_done = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule
